// File: rtl/baud_pkg.sv
// baud_pkg -- shared constants, FSM state type and baud coefficient table
// for the UART baud-rate change controller (baud_ctrl).
//
// Coefficients assume a 50 MHz in_clk and 16x oversampling. Index 7 is
// reserved; a zero coefficient marks an index as invalid.
package baud_pkg;

   localparam int COEF_W = 14;
   localparam int SEL_W  = 3;
   localparam int CNT_W  = 16;

   typedef enum logic [2:0] {
      IDLE,
      DRAIN,
      LOAD,
      SETTLE,
      DONE
   } baud_state_e;

   localparam logic [COEF_W-1:0] BAUD_COEF [0:(1<<SEL_W)-1] = '{
      14'd10417, 14'd2604, 14'd651, 14'd326,
      14'd163,   14'd81,   14'd27,  14'd0
   };

endpackage

// File: rtl/baud_ctrl.sv
// baud_ctrl -- sequences a safe baud-rate change on a UART.
//
// A request is accepted in IDLE. The controller holds both transmitter and
// receiver off new frames, waits for them to go idle (bounded by
// DRAIN_TIMEOUT), restarts the clock divider with the new coefficient, lets
// the divider run one full period, then commits the new index.
//
// Ports:
//   in_clk, rst          clock, async active-low reset
//   cfg_valid/cfg_ready  request handshake, cfg_sel = requested index
//   tx_busy, rx_busy     transmitter / receiver mid-frame
//   tx_hold, rx_hold     block new frames while high
//   coef, div_rst_n      coefficient and active-low restart for the divider
//   cur_sel              index currently applied
//   cfg_done, cfg_err    one-cycle success / failure pulses
module baud_ctrl
   import baud_pkg::*;
#(
   parameter logic [SEL_W-1:0] DEFAULT_SEL   = 3'd3,
   parameter logic [CNT_W-1:0] DRAIN_TIMEOUT = 16'd50000
) (
   input  logic              in_clk,
   input  logic              rst,
   input  logic              cfg_valid,
   input  logic [SEL_W-1:0]  cfg_sel,
   output logic              cfg_ready,
   input  logic              tx_busy,
   input  logic              rx_busy,
   output logic              tx_hold,
   output logic              rx_hold,
   output logic [COEF_W-1:0] coef,
   output logic              div_rst_n,
   output logic [SEL_W-1:0]  cur_sel,
   output logic              cfg_done,
   output logic              cfg_err
);

   baud_state_e       state_q, state_d;
   logic [SEL_W-1:0]  sel_q, cur_sel_q;
   logic [COEF_W-1:0] coef_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              same_q, err_q;

   logic accept, sel_invalid, sel_same, cnt_last, busy;

   assign accept      = cfg_valid && (state_q == IDLE);
   assign sel_invalid = (BAUD_COEF[cfg_sel] == '0);
   assign sel_same    = (cfg_sel == cur_sel_q);
   assign busy        = tx_busy || rx_busy;
   // Last cycle of the current count; also true at 0 so a zero load never wraps.
   assign cnt_last    = (cnt_q <= CNT_W'(1));

   // Next state and state-decoded outputs
   always_comb begin
      state_d   = state_q;
      cfg_ready = 1'b0;
      tx_hold   = 1'b1;
      rx_hold   = 1'b1;
      div_rst_n = 1'b1;
      unique case (state_q)
         IDLE: begin
            cfg_ready = 1'b1;
            tx_hold   = 1'b0;
            rx_hold   = 1'b0;
            if (cfg_valid && !sel_invalid && !sel_same)
               state_d = DRAIN;
         end
         DRAIN: begin
            if (!busy)
               state_d = LOAD;
            else if (cnt_last)
               state_d = IDLE;
         end
         LOAD: begin
            div_rst_n = 1'b0;
            state_d   = SETTLE;
         end
         SETTLE: begin
            if (cnt_last)
               state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge in_clk or negedge rst) begin
      if (!rst)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // Datapath: latched request, applied coefficient/index, shared counter
   always_ff @(posedge in_clk or negedge rst) begin
      if (!rst) begin
         sel_q     <= DEFAULT_SEL;
         cur_sel_q <= DEFAULT_SEL;
         coef_q    <= BAUD_COEF[DEFAULT_SEL];
         cnt_q     <= '0;
         same_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         if (accept)
            sel_q <= cfg_sel;

         // Coefficient changes on the edge into LOAD so the divider sees the
         // new value during its restart cycle.
         if (state_q == DRAIN && state_d == LOAD)
            coef_q <= BAUD_COEF[sel_q];

         if (state_q == DONE)
            cur_sel_q <= sel_q;

         if (state_q != DRAIN && state_d == DRAIN)
            cnt_q <= DRAIN_TIMEOUT;
         else if (state_q != SETTLE && state_d == SETTLE)
            cnt_q <= {{(CNT_W-COEF_W){1'b0}}, coef_q};
         else if (cnt_q != '0)
            cnt_q <= cnt_q - CNT_W'(1);

         // Pulses that complete without leaving IDLE
         same_q <= accept && !sel_invalid && sel_same;
         err_q  <= (accept && sel_invalid) ||
                   (state_q == DRAIN && busy && cnt_last);
      end
   end

   assign coef     = coef_q;
   assign cur_sel  = cur_sel_q;
   assign cfg_done = (state_q == DONE) || same_q;
   assign cfg_err  = err_q;

endmodule

// File: tb/tb_baud_ctrl.sv
// tb_baud_ctrl -- self-checking bench for baud_ctrl: vector table of
// requests with a pulse scoreboard, plus directed busy, timeout and
// mid-operation reset sequences.
module tb_baud_ctrl;

   logic        in_clk = 1'b0;
   logic        rst    = 1'b0;
   logic        cfg_valid = 1'b0;
   logic [2:0]  cfg_sel   = 3'd0;
   logic        tx_busy   = 1'b0;
   logic        rx_busy   = 1'b0;
   logic        cfg_ready, tx_hold, rx_hold, div_rst_n, cfg_done, cfg_err;
   logic [13:0] coef;
   logic [2:0]  cur_sel;

   logic        t_cfg_valid = 1'b0;
   logic [2:0]  t_cfg_sel   = 3'd0;
   logic        t_tx_busy   = 1'b0;
   logic        t_rx_busy   = 1'b0;
   logic        t_cfg_ready, t_tx_hold, t_rx_hold, t_div_rst_n, t_cfg_done, t_cfg_err;
   logic [13:0] t_coef;
   logic [2:0]  t_cur_sel;

   baud_ctrl dut (
      .in_clk(in_clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_sel(cfg_sel),
      .cfg_ready(cfg_ready), .tx_busy(tx_busy), .rx_busy(rx_busy),
      .tx_hold(tx_hold), .rx_hold(rx_hold), .coef(coef), .div_rst_n(div_rst_n),
      .cur_sel(cur_sel), .cfg_done(cfg_done), .cfg_err(cfg_err)
   );

   baud_ctrl #(.DEFAULT_SEL(3'd3), .DRAIN_TIMEOUT(16'd20)) dut_t (
      .in_clk(in_clk), .rst(rst), .cfg_valid(t_cfg_valid), .cfg_sel(t_cfg_sel),
      .cfg_ready(t_cfg_ready), .tx_busy(t_tx_busy), .rx_busy(t_rx_busy),
      .tx_hold(t_tx_hold), .rx_hold(t_rx_hold), .coef(t_coef), .div_rst_n(t_div_rst_n),
      .cur_sel(t_cur_sel), .cfg_done(t_cfg_done), .cfg_err(t_cfg_err)
   );

   always #5 in_clk = ~in_clk;

   int cyc = 0;
   always @(posedge in_clk) cyc <= cyc + 1;

   typedef struct {
      logic [2:0]  sel;
      logic        is_err;
      logic [13:0] coef;
      logic [2:0]  sel_after;
      int          lat;
   } vec_t;

   typedef struct {
      logic        is_err;
      logic [13:0] coef;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[12];

   int checks = 0, failures = 0;
   int npulses = 0, pulse_cyc = 0, lowcnt = 0, load_cyc = 0, holdcnt = 0, hold_start = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Monitor: invariants, scoreboard pop on each pulse, LOAD/hold bookkeeping
   initial begin
      exp_t e;
      logic hold_prev;
      hold_prev = 1'b0;
      forever begin
         @(negedge in_clk);
         if (!rst) begin
            if (cfg_done || cfg_err) chk("pulse_in_reset", cfg_done | cfg_err, 0);
         end else begin
            if (cfg_done && cfg_err) chk("done_err_excl", cfg_done & cfg_err, 0);
            if (tx_hold != rx_hold) chk("hold_match", rx_hold, tx_hold);
            if (cfg_ready == tx_hold) chk("ready_vs_hold", cfg_ready, !tx_hold);
            if (!div_rst_n) begin
               lowcnt++;
               load_cyc = cyc;
            end
            if (tx_hold) holdcnt++;
            if (tx_hold && !hold_prev) hold_start = cyc;
            if (cfg_done || cfg_err) begin
               chk("pulse_expected", sb.size() > 0, 1);
               if (sb.size() > 0) begin
                  e = sb.pop_front();
                  chk("pulse_is_err", cfg_err, e.is_err);
                  chk("pulse_coef", coef, e.coef);
               end
               pulse_cyc = cyc;
               npulses++;
            end
         end
         hold_prev = tx_hold;
      end
   end

   task automatic wait_pulse(input int np0, input int bound);
      int n = 0;
      while (npulses == np0 && n < bound) begin
         @(negedge in_clk); #1;
         n++;
      end
      chk("pulse_seen", npulses - np0, 1);
   endtask

   task automatic do_req(input vec_t v);
      int acc, low0, hold0, np0;
      @(posedge in_clk); #1;
      cfg_valid = 1'b1;
      cfg_sel   = v.sel;
      acc   = cyc;
      low0  = lowcnt;
      hold0 = holdcnt;
      np0   = npulses;
      sb.push_back('{v.is_err, v.coef});
      @(posedge in_clk); #1;
      cfg_valid = 1'b0;
      wait_pulse(np0, v.lat + 10);
      chk("latency", pulse_cyc - acc, v.lat);
      @(negedge in_clk); #1;
      chk("cur_sel_after", cur_sel, v.sel_after);
      chk("hold_after", tx_hold, 0);
      chk("ready_after", cfg_ready, 1);
      if (v.lat > 1) begin
         chk("load_cycles", lowcnt - low0, 1);
         chk("load_at", load_cyc - acc, 2);
         chk("hold_start", hold_start - acc, 1);
         chk("hold_len", holdcnt - hold0, v.lat);
      end else begin
         chk("no_load", lowcnt - low0, 0);
         chk("no_hold", holdcnt - hold0, 0);
      end
   endtask

   // Request while one side is busy for n DRAIN cycles; a second request
   // inside DRAIN must be ignored.
   task automatic busy_req(input logic [2:0] sel, input logic [13:0] c, input logic use_rx, input int n);
      int acc, f, low0, np0;
      @(posedge in_clk); #1;
      if (use_rx) rx_busy = 1'b1; else tx_busy = 1'b1;
      cfg_valid = 1'b1;
      cfg_sel   = sel;
      acc  = cyc;
      low0 = lowcnt;
      np0  = npulses;
      sb.push_back('{1'b0, c});
      @(posedge in_clk); #1;
      cfg_valid = 1'b0;
      repeat (2) @(posedge in_clk);
      #1;
      cfg_valid = 1'b1;
      cfg_sel   = 3'd7;
      @(negedge in_clk);
      chk("ready_in_drain", cfg_ready, 0);
      chk("hold_in_drain", tx_hold, 1);
      @(posedge in_clk); #1;
      cfg_valid = 1'b0;
      repeat (n - 3) @(posedge in_clk);
      #1;
      chk("no_load_while_busy", lowcnt - low0, 0);
      tx_busy = 1'b0;
      rx_busy = 1'b0;
      f = cyc;
      wait_pulse(np0, c + 20);
      chk("busy_load_at", load_cyc - f, 1);
      chk("busy_load_cycles", lowcnt - low0, 1);
      chk("busy_done_at", pulse_cyc - f, 2 + c);
      repeat (6) @(negedge in_clk);
      #1;
      chk("ignored_not_queued", npulses - np0, 1);
      chk("busy_cur_sel", cur_sel, sel);
   endtask

   task automatic t_timeout();
      int acc, n;
      logic seen_load;
      seen_load = 1'b0;
      @(posedge in_clk); #1;
      t_tx_busy   = 1'b1;
      t_cfg_valid = 1'b1;
      t_cfg_sel   = 3'd5;
      acc = cyc;
      @(posedge in_clk); #1;
      t_cfg_valid = 1'b0;
      n = 0;
      while (!t_cfg_err && !t_cfg_done && n < 60) begin
         @(negedge in_clk); #1;
         if (!t_div_rst_n) seen_load = 1'b1;
         if (n == 4) chk("t_hold_drain", t_tx_hold & t_rx_hold, 1);
         n++;
      end
      chk("t_err_seen", t_cfg_err, 1);
      chk("t_done_low", t_cfg_done, 0);
      chk("t_err_at", cyc - acc, 21);
      chk("t_no_load", seen_load, 0);
      @(negedge in_clk); #1;
      chk("t_err_one_cycle", t_cfg_err, 0);
      chk("t_coef", t_coef, 326);
      chk("t_cur_sel", t_cur_sel, 3);
      chk("t_ready", t_cfg_ready, 1);
      t_tx_busy = 1'b0;
   endtask

   task automatic check_defaults(input string tag);
      chk({tag, "_coef"}, coef, 326);
      chk({tag, "_cur_sel"}, cur_sel, 3);
      chk({tag, "_ready"}, cfg_ready, 1);
      chk({tag, "_tx_hold"}, tx_hold, 0);
      chk({tag, "_rx_hold"}, rx_hold, 0);
      chk({tag, "_div_rst_n"}, div_rst_n, 1);
      chk({tag, "_done"}, cfg_done, 0);
      chk({tag, "_err"}, cfg_err, 0);
   endtask

   initial begin
      int acc, np0;
      // sel, err, coef at pulse, cur_sel after, accept-to-pulse latency
      vecs[0]  = '{3'd6, 1'b0, 14'd27,    3'd6, 30};
      vecs[1]  = '{3'd7, 1'b1, 14'd27,    3'd6, 1};
      vecs[2]  = '{3'd6, 1'b0, 14'd27,    3'd6, 1};
      vecs[3]  = '{3'd5, 1'b0, 14'd81,    3'd5, 84};
      vecs[4]  = '{3'd4, 1'b0, 14'd163,   3'd4, 166};
      vecs[5]  = '{3'd3, 1'b0, 14'd326,   3'd3, 329};
      vecs[6]  = '{3'd2, 1'b0, 14'd651,   3'd2, 654};
      vecs[7]  = '{3'd7, 1'b1, 14'd651,   3'd2, 1};
      vecs[8]  = '{3'd1, 1'b0, 14'd2604,  3'd1, 2607};
      vecs[9]  = '{3'd0, 1'b0, 14'd10417, 3'd0, 10420};
      vecs[10] = '{3'd0, 1'b0, 14'd10417, 3'd0, 1};
      vecs[11] = '{3'd6, 1'b0, 14'd27,    3'd6, 30};

      repeat (3) @(negedge in_clk);
      check_defaults("in_reset");
      @(posedge in_clk); #1;
      rst = 1'b1;
      @(negedge in_clk); #1;
      check_defaults("after_reset");

      t_timeout();

      for (int i = 0; i < 12; i++) do_req(vecs[i]);

      busy_req(3'd5, 14'd81, 1'b0, 100);
      busy_req(3'd6, 14'd27, 1'b1, 10);

      // Reset during SETTLE of a change to index 0
      @(posedge in_clk); #1;
      cfg_valid = 1'b1;
      cfg_sel   = 3'd0;
      acc = cyc;
      np0 = npulses;
      sb.push_back('{1'b0, 14'd10417});
      @(posedge in_clk); #1;
      cfg_valid = 1'b0;
      repeat (9) @(posedge in_clk);
      @(negedge in_clk);
      chk("settle_hold", tx_hold, 1);
      chk("settle_div_run", div_rst_n, 1);
      chk("settle_coef", coef, 10417);
      chk("settle_at", cyc - acc, 10);
      @(posedge in_clk); #1;
      rst = 1'b0;
      sb.delete();
      @(negedge in_clk); #1;
      check_defaults("mid_reset");
      repeat (2) @(posedge in_clk);
      #1;
      rst = 1'b1;
      repeat (20) @(negedge in_clk);
      #1;
      chk("no_pulse_after_reset", npulses - np0, 0);
      check_defaults("post_abort");
      chk("sb_empty", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
